// File: rtl/key_pkg.sv
// key_pkg: shared types for the keypad event path.
//   KEY_CODE_W  width of a scanner key code
//   NUM_KEYS    number of distinct keys (codes 0..NUM_KEYS-1)
//   key_code_t  key code type
//   kstate_t    press qualification FSM state
package key_pkg;

    localparam int unsigned KEY_CODE_W = 5;
    localparam int unsigned NUM_KEYS   = 20;

    typedef logic [KEY_CODE_W-1:0] key_code_t;

    typedef enum logic [1:0] {
        IDLE,
        QUAL,
        HELD
    } kstate_t;

endpackage

// File: rtl/key_fifo.sv
// key_fifo: synchronous FIFO with a registered head output.
//   clk, rst   clock, asynchronous active-high reset
//   push, din  write request and data; dropped when full without a same-cycle pop
//   pop        read request; ignored when empty
//   clr        synchronous flush; same-cycle push/pop are discarded
//   head       registered head entry, 0 while empty
//   valid      registered "head holds an entry"
//   full, empty, fill  occupancy status (fill is exact, 0..DEPTH)
//   drop       a push was refused because the FIFO was full
module key_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [W-1:0]             din,
    input  logic                     pop,
    input  logic                     clr,
    output logic [W-1:0]             head,
    output logic                     valid,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   fill,
    output logic                     drop
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr_n;
    logic [AW:0]   fill_n;
    logic [W-1:0]  head_n;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (fill == (AW+1)'(DEPTH));
    assign empty   = (fill == '0);
    assign pop_ok  = pop & ~empty & ~clr;
    // At full a same-cycle pop frees the slot being written.
    assign push_ok = push & ~clr & (~full | pop_ok);
    assign drop    = push & ~clr & full & ~pop_ok;

    always_comb begin
        fill_n   = fill;
        rd_ptr_n = rd_ptr;
        if (push_ok && !pop_ok) begin
            fill_n = fill + 1'b1;
        end else if (pop_ok && !push_ok) begin
            fill_n = fill - 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_n = rd_ptr + 1'b1;
        end
        // The next head is the incoming word when it lands in the slot the
        // read pointer moves to (FIFO empty, or fill==1 with push+pop).
        if (fill_n == '0) begin
            head_n = '0;
        end else if (push_ok && (wr_ptr == rd_ptr_n)) begin
            head_n = din;
        end else begin
            head_n = mem[rd_ptr_n];
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            fill   <= '0;
            head   <= '0;
            valid  <= 1'b0;
        end else if (clr) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            fill   <= '0;
            head   <= '0;
            valid  <= 1'b0;
        end else begin
            rd_ptr <= rd_ptr_n;
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            fill  <= fill_n;
            head  <= head_n;
            valid <= (fill_n != '0);
        end
    end

endmodule

// File: rtl/key_event_ctrl.sv
// key_event_ctrl: turns keypad scanner strobes into one event per press.
//   clk, rst     clock, asynchronous active-high reset
//   key_strobe   scanner key-down strobe
//   key_code     scanner key code, valid while key_strobe=1
//   evt_valid    FIFO head holds an event
//   evt_code     event code at FIFO head (0 when evt_valid=0)
//   evt_ready    consumer accepts head when evt_valid & evt_ready
//   clr          synchronous flush of FIFO and overflow flag
//   overflow     sticky: an accepted key was dropped on a full FIFO
//   fill         FIFO occupancy 0..DEPTH
// Optional feature: define KEY_REPEAT_EN for auto-repeat every REPEAT_CYC
// cycles while a key stays held.
module key_event_ctrl
    import key_pkg::*;
#(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned HOLD_CYC   = 16,
    parameter int unsigned REPEAT_CYC = 1000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     key_strobe,
    input  logic [KEY_CODE_W-1:0]    key_code,
    output logic                     evt_valid,
    output logic [KEY_CODE_W-1:0]    evt_code,
    input  logic                     evt_ready,
    input  logic                     clr,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   fill
);

    localparam int unsigned QW = $clog2(HOLD_CYC) + 1;

    kstate_t       state;
    key_code_t     cur_code;
    logic [QW-1:0] qcnt;
    logic          push;
    key_code_t     push_code;
    logic          pop;
    logic          drop;
    logic          fifo_full;
    logic          fifo_empty;

    if (REPEAT_CYC == 0) begin : g_repeat_period_zero
        // REPEAT_CYC must be >= 1; nothing is built for this case.
    end

`ifdef KEY_REPEAT_EN
    localparam int unsigned RW = $clog2(REPEAT_CYC) + 1;
    logic [RW-1:0] rcnt;
    logic          rep_hit;
    assign rep_hit = (state == HELD) && key_strobe && (rcnt == RW'(REPEAT_CYC - 1));
`endif

    assign pop = evt_valid & evt_ready;

    // Push is decoded from current state and inputs so the FIFO captures the
    // event on the last qualifying cycle; evt_valid follows one cycle later.
    always_comb begin
        push      = 1'b0;
        push_code = cur_code;
        case (state)
            IDLE: begin
                if (key_strobe && (HOLD_CYC == 1)) begin
                    push      = 1'b1;
                    push_code = key_code;
                end
            end
            QUAL: begin
                if (key_strobe && (key_code == cur_code) && (qcnt == QW'(HOLD_CYC - 1))) begin
                    push = 1'b1;
                end
            end
            HELD: begin
`ifdef KEY_REPEAT_EN
                push = rep_hit;
`endif
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cur_code <= '0;
            qcnt     <= '0;
            overflow <= 1'b0;
`ifdef KEY_REPEAT_EN
            rcnt     <= '0;
`endif
        end else begin
            overflow <= clr ? 1'b0 : (overflow | drop);
            if (clr) begin
                // A key held through clr is parked in HELD so it is not re-reported.
                state <= key_strobe ? HELD : IDLE;
                qcnt  <= '0;
                if (key_strobe && (state != HELD)) begin
                    cur_code <= key_code;
                end
`ifdef KEY_REPEAT_EN
                rcnt <= '0;
`endif
            end else begin
                case (state)
                    IDLE: begin
                        if (key_strobe) begin
                            cur_code <= key_code;
                            qcnt     <= QW'(1);
                            if (HOLD_CYC == 1) begin
                                state <= HELD;
`ifdef KEY_REPEAT_EN
                                rcnt  <= '0;
`endif
                            end else begin
                                state <= QUAL;
                            end
                        end
                    end
                    QUAL: begin
                        if (!key_strobe) begin
                            state <= IDLE;
                            qcnt  <= '0;
                        end else if (key_code != cur_code) begin
                            cur_code <= key_code;
                            qcnt     <= QW'(1);
                        end else if (qcnt == QW'(HOLD_CYC - 1)) begin
                            state <= HELD;
                            qcnt  <= '0;
`ifdef KEY_REPEAT_EN
                            rcnt  <= '0;
`endif
                        end else begin
                            qcnt <= qcnt + 1'b1;
                        end
                    end
                    HELD: begin
                        if (!key_strobe) begin
                            state <= IDLE;
                        end
`ifdef KEY_REPEAT_EN
                        else begin
                            rcnt <= rep_hit ? '0 : rcnt + 1'b1;
                        end
`endif
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    key_fifo #(
        .DEPTH (DEPTH),
        .W     (KEY_CODE_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (push_code),
        .pop   (pop),
        .clr   (clr),
        .head  (evt_code),
        .valid (evt_valid),
        .full  (fifo_full),
        .empty (fifo_empty),
        .fill  (fill),
        .drop  (drop)
    );

endmodule

// File: tb/tb_key_event_ctrl.sv
// tb_key_event_ctrl: directed bench for key_event_ctrl (DEPTH=4, HOLD_CYC=16).
// With KEY_REPEAT_EN defined the DUT is built with REPEAT_CYC=100 and an
// auto-repeat hold is added.
module tb_key_event_ctrl;

`ifdef KEY_REPEAT_EN
    localparam int unsigned RC = 100;
`else
    localparam int unsigned RC = 1000;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       key_strobe;
    logic [4:0] key_code;
    logic       evt_valid;
    logic [4:0] evt_code;
    logic       evt_ready;
    logic       clr;
    logic       overflow;
    logic [2:0] fill;

    int total = 0;
    int bad   = 0;
    int nev;
    int lastc;

    typedef struct {
        logic [4:0] code;
        int         len;
        int         efill;
        int         eovf;
        int         evalid;
        int         ehead;
    } vec_t;

    vec_t tbl [6];

    key_event_ctrl #(
        .DEPTH      (4),
        .HOLD_CYC   (16),
        .REPEAT_CYC (RC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .key_strobe (key_strobe),
        .key_code   (key_code),
        .evt_valid  (evt_valid),
        .evt_code   (evt_code),
        .evt_ready  (evt_ready),
        .clr        (clr),
        .overflow   (overflow),
        .fill       (fill)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One cycle, counting cycles where an event is presented.
    task automatic sample();
        tick();
        if (evt_valid) begin
            nev++;
            lastc = int'(evt_code);
        end
    endtask

    task automatic press(input logic [4:0] code, input int len);
        key_strobe = 1'b1;
        key_code   = code;
        repeat (len) tick();
        key_strobe = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        //              code len fill ovf valid head
        tbl[0] = '{5'd3, 10, 0, 0, 0, 0};
        tbl[1] = '{5'd1, 16, 1, 0, 1, 1};
        tbl[2] = '{5'd2, 16, 2, 0, 1, 1};
        tbl[3] = '{5'd3, 16, 3, 0, 1, 1};
        tbl[4] = '{5'd4, 16, 4, 0, 1, 1};
        tbl[5] = '{5'd5, 16, 4, 1, 1, 1};

        // Reset with the strobe already high.
        rst        = 1'b1;
        key_strobe = 1'b1;
        key_code   = 5'd9;
        evt_ready  = 1'b0;
        clr        = 1'b0;
        tick();
        tick();
        chk("rst_valid", int'(evt_valid), 0);
        chk("rst_code", int'(evt_code), 0);
        chk("rst_ovf", int'(overflow), 0);
        chk("rst_fill", int'(fill), 0);
        rst = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            tick();
            if (i == 15) chk("rel_valid_c15", int'(evt_valid), 0);
            if (i == 16) begin
                chk("rel_valid_c16", int'(evt_valid), 1);
                chk("rel_code", int'(evt_code), 9);
            end
        end
        evt_ready = 1'b1;
        tick();
        chk("pop_valid", int'(evt_valid), 0);
        chk("pop_code0", int'(evt_code), 0);
        nev = 0;
        repeat (20) sample();
        chk("held_no_second", nev, 0);
        key_strobe = 1'b0;
        tick();
        tick();

        // Single event with immediate acceptance, long hold.
        nev = 0; lastc = -1;
        key_strobe = 1'b1;
        key_code   = 5'd7;
        repeat (40) sample();
        key_strobe = 1'b0;
        repeat (3) sample();
        chk("one_evt_cnt", nev, 1);
        chk("one_evt_code", lastc, 7);

        // Short press rejected; code change restarts qualification.
        nev = 0; lastc = -1;
        key_strobe = 1'b1;
        key_code   = 5'd3;
        repeat (10) sample();
        key_strobe = 1'b0;
        repeat (3) sample();
        chk("short_press", nev, 0);
        key_strobe = 1'b1;
        key_code   = 5'd3;
        repeat (8) sample();
        key_code = 5'd5;
        repeat (16) sample();
        repeat (4) sample();
        key_strobe = 1'b0;
        repeat (3) sample();
        chk("restart_cnt", nev, 1);
        chk("restart_code", lastc, 5);

        // Fill to full and overflow with the consumer stalled.
        evt_ready = 1'b0;
        for (int r = 0; r < 6; r++) begin
            press(tbl[r].code, tbl[r].len);
            chk($sformatf("tbl%0d_fill", r), int'(fill), tbl[r].efill);
            chk($sformatf("tbl%0d_ovf", r), int'(overflow), tbl[r].eovf);
            chk($sformatf("tbl%0d_valid", r), int'(evt_valid), tbl[r].evalid);
            chk($sformatf("tbl%0d_head", r), int'(evt_code), tbl[r].ehead);
        end
        evt_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            chk($sformatf("drain_code%0d", k), int'(evt_code), k);
            chk($sformatf("drain_fill%0d", k), int'(fill), 5 - k);
            tick();
        end
        chk("drain_empty", int'(fill), 0);
        chk("drain_valid", int'(evt_valid), 0);
        evt_ready = 1'b0;

        // Simultaneous push and pop at full.
        for (int k = 6; k <= 9; k++) press(5'(k), 16);
        chk("full_fill", int'(fill), 4);
        key_strobe = 1'b1;
        key_code   = 5'd10;
        repeat (15) tick();
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;
        chk("pp_fill", int'(fill), 4);
        chk("pp_ovf", int'(overflow), 1);
        chk("pp_head", int'(evt_code), 7);
        key_strobe = 1'b0;
        tick();
        evt_ready = 1'b1;
        for (int k = 7; k <= 10; k++) begin
            chk($sformatf("wrap_code%0d", k), int'(evt_code), k);
            tick();
        end
        chk("wrap_empty", int'(fill), 0);
        evt_ready = 1'b0;

        // clr while a key is held with two entries queued.
        press(5'd11, 16);
        key_strobe = 1'b1;
        key_code   = 5'd12;
        repeat (18) tick();
        chk("preclr_fill", int'(fill), 2);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_fill", int'(fill), 0);
        chk("clr_valid", int'(evt_valid), 0);
        chk("clr_ovf", int'(overflow), 0);
        chk("clr_code", int'(evt_code), 0);
        nev = 0;
        repeat (30) sample();
        chk("clr_held_quiet", nev, 0);
        key_strobe = 1'b0;
        tick();
        tick();
        press(5'd14, 16);
        chk("post_clr_fill", int'(fill), 1);
        chk("post_clr_head", int'(evt_code), 14);
        evt_ready = 1'b1;
        tick();
        chk("post_clr_pop", int'(fill), 0);

`ifdef KEY_REPEAT_EN
        nev = 0; lastc = -1;
        key_strobe = 1'b1;
        key_code   = 5'd15;
        repeat (300) sample();
        key_strobe = 1'b0;
        repeat (3) sample();
        chk("repeat_cnt", nev, 3);
        chk("repeat_code", lastc, 15);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
